// File: rtl/lc3b_types.sv
// Shared LC-3b word and line types used by the line memory responder.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   localparam int unsigned LineOffsetBits = 4;  // byte offset within a 16-byte line
   localparam int unsigned CntBits        = 4;  // holds LATENCY-1 for LATENCY up to 15

endpackage

// File: rtl/line_store.sv
// Line storage array: synchronous write, combinational read, contents never reset.
module line_store
   import lc3b_types::*;
#(
   parameter int unsigned INDEX_BITS = 12,
   parameter string       INIT_FILE  = ""
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [INDEX_BITS-1:0] waddr_i,
   input  lc3b_line              wdata_i,
   input  logic [INDEX_BITS-1:0] raddr_i,
   output lc3b_line              rdata_o
);

   localparam int unsigned Lines = 1 << INDEX_BITS;

   lc3b_line mem_q [Lines];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_memory_responder.sv
// Fixed-latency line memory: one outstanding read or write of a 128-bit line at a time,
// with a sticky flag for initiator protocol violations.
module line_memory_responder
   import lc3b_types::*;
#(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned INDEX_BITS = 12,
   parameter string       INIT_FILE  = ""
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     pmem_read,
   input  logic     pmem_write,
   input  lc3b_word pmem_address,
   input  lc3b_line pmem_wdata,
   output lc3b_line pmem_rdata,
   output logic     pmem_resp,
   output logic     proto_err
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   localparam logic [CntBits-1:0] CntLoad = CntBits'(LATENCY - 1);

   state_e                 state_q, state_d;
   logic [CntBits-1:0]     cnt_q, cnt_d;
   logic [INDEX_BITS-1:0]  idx_q, idx_d;
   logic                   is_write_q, is_write_d;
   lc3b_line               wdata_q, wdata_d;
   lc3b_line               rdata_q, rdata_d;
   logic                   resp_q, resp_d;
   logic                   err_q, err_d;
   lc3b_line               store_rdata;
   logic                   store_we;
   logic                   req;
   logic                   unused_addr_offset;

   assign req                = pmem_read | pmem_write;
   assign unused_addr_offset = ^pmem_address[LineOffsetBits-1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      is_write_d = is_write_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               idx_d      = pmem_address[INDEX_BITS+LineOffsetBits-1:LineOffsetBits];
               is_write_d = pmem_write;
               wdata_d    = pmem_wdata;
               cnt_d      = CntLoad;
               if (pmem_read && pmem_write) begin
                  err_d = 1'b1;
               end
               state_d = (LATENCY == 1) ? StResp : StBusy;
            end
         end
         StBusy: begin
            if (!req) begin
               // Initiator gave up: drop the operation without a response or a write.
               state_d = StIdle;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               if (pmem_write != is_write_q) begin
                  err_d = 1'b1;
               end
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CntBits'(1)) begin
                  state_d = StResp;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      resp_d = (state_d == StResp);
      // The store is read at the next index so the line is captured on entry to StResp.
      if ((state_d == StResp) && !is_write_d) begin
         rdata_d = store_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         is_write_q <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         resp_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         is_write_q <= is_write_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         resp_q     <= resp_d;
         err_q      <= err_d;
      end
   end

   // Writes commit on the edge that ends the response cycle.
   assign store_we = (state_q == StResp) && is_write_q;

   line_store #(
      .INDEX_BITS (INDEX_BITS),
      .INIT_FILE  (INIT_FILE)
   ) u_line_store (
      .clk_i   (clk),
      .we_i    (store_we),
      .waddr_i (idx_q),
      .wdata_i (wdata_q),
      .raddr_i (idx_d),
      .rdata_o (store_rdata)
   );

   assign pmem_rdata = rdata_q;
   assign pmem_resp  = resp_q;
   assign proto_err  = err_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Bench for line_memory_responder: LATENCY=4 and LATENCY=1 instances checked every cycle
// against a transaction-level model of response timing, read data and the error flag.
module tb_line_memory_responder;
   import lc3b_types::*;

   localparam int Never = 32'h3fff_ffff;
   localparam int NPool = 8;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic     rst_s  [2];
   logic     rd_s   [2];
   logic     wr_s   [2];
   lc3b_word addr_s [2];
   lc3b_line wd_s   [2];
   lc3b_line rdata_w [2];
   logic     resp_w  [2];
   logic     err_w   [2];

   // Model state: one outstanding transaction per port, described by when it completes.
   int          due       [2];
   int          err_from  [2];
   bit          op_wr     [2];
   logic [11:0] idx_m     [2];
   lc3b_line    data_m    [2];
   lc3b_line    exp_rdata [2];
   int          resp_cyc  [2];
   lc3b_line    mdl_mem   [int];

   lc3b_word pool_addr [NPool] = '{16'h0000, 16'h0010, 16'h2000, 16'h0040,
                                   16'h0080, 16'h3000, 16'hFFF0, 16'h1230};
   lc3b_line pool_data [2][NPool];

   line_memory_responder #(.LATENCY(4), .INDEX_BITS(12)) u_dut_l4 (
      .clk          (clk),
      .reset        (rst_s[0]),
      .pmem_read    (rd_s[0]),
      .pmem_write   (wr_s[0]),
      .pmem_address (addr_s[0]),
      .pmem_wdata   (wd_s[0]),
      .pmem_rdata   (rdata_w[0]),
      .pmem_resp    (resp_w[0]),
      .proto_err    (err_w[0])
   );

   line_memory_responder #(.LATENCY(1), .INDEX_BITS(12)) u_dut_l1 (
      .clk          (clk),
      .reset        (rst_s[1]),
      .pmem_read    (rd_s[1]),
      .pmem_write   (wr_s[1]),
      .pmem_address (addr_s[1]),
      .pmem_wdata   (wd_s[1]),
      .pmem_rdata   (rdata_w[1]),
      .pmem_resp    (resp_w[1]),
      .proto_err    (err_w[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input int p);
      return (p == 0) ? 4 : 1;
   endfunction

   function automatic int key(input int p, input logic [11:0] i);
      return p * 65536 + int'(i);
   endfunction

   task automatic chk(input string name, input int p, input lc3b_line got, input lc3b_line want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s port%0d cyc %0d got %h want %h", name, p, cyc, got, want);
      end
   endtask

   task automatic set_err(input int p);
      if (err_from[p] > cyc + 1) err_from[p] = cyc + 1;
   endtask

   // Single compare process: outputs against the model every cycle.
   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (cyc == due[p]) begin
            if (op_wr[p]) mdl_mem[key(p, idx_m[p])] = data_m[p];
            else exp_rdata[p] = mdl_mem.exists(key(p, idx_m[p])) ?
                                mdl_mem[key(p, idx_m[p])] : '0;
         end
         if (resp_w[p]) resp_cyc[p] = cyc;
         chk("resp", p, lc3b_line'(resp_w[p]), lc3b_line'(cyc == due[p]));
         chk("rdata", p, rdata_w[p], exp_rdata[p]);
         chk("proto_err", p, lc3b_line'(err_w[p]), lc3b_line'(cyc >= err_from[p]));
      end
   end

   task automatic idle(input int p, input int n);
      rd_s[p] = 1'b0;
      wr_s[p] = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset(input int p);
      rst_s[p]     = 1'b1;
      rd_s[p]      = 1'b0;
      wr_s[p]      = 1'b0;
      due[p]       = -1;
      err_from[p]  = Never;
      exp_rdata[p] = '0;
      @(posedge clk);
      #2;
      rst_s[p] = 1'b0;
   endtask

   // Issue one request on an idle port; returns in the cycle after it ends, inputs untouched.
   task automatic txn(input int p, input bit rd, input bit wr, input lc3b_word a,
                      input lc3b_line d, input int drop_at, input int chg_at,
                      input int flip_at, input int rst_at, output int acc);
      rd_s[p]   = rd;
      wr_s[p]   = wr;
      addr_s[p] = a;
      wd_s[p]   = d;
      acc       = cyc;
      due[p]    = cyc + lat(p);
      op_wr[p]  = wr;
      idx_m[p]  = a[15:4];
      data_m[p] = d;
      if (rd && wr) set_err(p);
      for (int k = 1; k <= lat(p); k++) begin
         @(posedge clk);
         #2;
         if (k == lat(p)) break;
         if (k == drop_at) begin
            rd_s[p] = 1'b0;
            wr_s[p] = 1'b0;
            due[p]  = -1;
            set_err(p);
            @(posedge clk);
            #2;
            return;
         end
         if (k == rst_at) begin
            rst_s[p]     = 1'b1;
            rd_s[p]      = 1'b0;
            wr_s[p]      = 1'b0;
            due[p]       = -1;
            err_from[p]  = Never;
            exp_rdata[p] = '0;
            #1;
            chk("rst_resp", p, lc3b_line'(resp_w[p]), '0);
            chk("rst_rdata", p, rdata_w[p], '0);
            chk("rst_err", p, lc3b_line'(err_w[p]), '0);
            @(posedge clk);
            #2;
            rst_s[p] = 1'b0;
            return;
         end
         if (k == chg_at) begin
            addr_s[p] = 16'h3000;
            wd_s[p]   = {$urandom, $urandom, $urandom, $urandom};
         end
         if (k == flip_at) begin
            if (op_wr[p]) begin
               rd_s[p] = 1'b1;
               wr_s[p] = 1'b0;
            end else begin
               wr_s[p] = 1'b1;
            end
            set_err(p);
         end
      end
      @(posedge clk);
      #2;
   endtask

   task automatic random_phase(input int p, input int n);
      int       acc;
      int       j;
      int       chg;
      lc3b_word a;
      for (int i = 0; i < n; i++) begin
         j   = $urandom_range(0, NPool - 1);
         a   = pool_addr[j] | lc3b_word'($urandom_range(0, 15));
         chg = (lat(p) > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lat(p) - 1) : 0;
         if ($urandom_range(0, 1) == 1)
            txn(p, 1'b0, 1'b1, a, {$urandom, $urandom, $urandom, $urandom}, 0, chg, 0, 0, acc);
         else
            txn(p, 1'b1, 1'b0, a, '0, 0, chg, 0, 0, acc);
         if ($urandom_range(0, 1) == 1) idle(p, $urandom_range(0, 3));
      end
      idle(p, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc %0d got no finish want finish", cyc);
      $fatal(1);
   end

   initial begin
      int       acc;
      int       r1;
      int       r2;
      lc3b_line k1;
      lc3b_line k2;
      for (int p = 0; p < 2; p++) begin
         rst_s[p]     = 1'b1;
         rd_s[p]      = 1'b0;
         wr_s[p]      = 1'b0;
         addr_s[p]    = '0;
         wd_s[p]      = '0;
         due[p]       = -1;
         err_from[p]  = Never;
         exp_rdata[p] = '0;
         resp_cyc[p]  = -1;
      end
      repeat (3) @(posedge clk);
      #2;
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      chk("reset_rdata", 0, rdata_w[0], '0);

      // Write then read within the same line, LATENCY=4.
      txn(0, 1'b0, 1'b1, 16'h1230, {16{8'hA5}}, 0, 0, 0, 0, acc);
      chk("wr_latency", 0, lc3b_line'(resp_cyc[0] - acc), lc3b_line'(4));
      txn(0, 1'b1, 1'b0, 16'h123F, '0, 0, 0, 0, 0, acc);
      chk("rd_latency", 0, lc3b_line'(resp_cyc[0] - acc), lc3b_line'(4));
      chk("rd_a5", 0, rdata_w[0], {16{8'hA5}});
      idle(0, 1);

      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < NPool; j++) begin
            pool_data[p][j] = {$urandom, $urandom, $urandom, $urandom};
            txn(p, 1'b0, 1'b1, pool_addr[j], pool_data[p][j], 0, 0, 0, 0, acc);
            idle(p, 1);
         end
      end

      // Reads held high back to back.
      txn(0, 1'b1, 1'b0, 16'h0000, '0, 0, 0, 0, 0, acc);
      r1 = resp_cyc[0];
      txn(0, 1'b1, 1'b0, 16'h0010, '0, 0, 0, 0, 0, acc);
      r2 = resp_cyc[0];
      chk("b2b_period", 0, lc3b_line'(r2 - r1), lc3b_line'(5));
      chk("b2b_rdata", 0, rdata_w[0], pool_data[0][1]);
      idle(0, 2);

      // Address switches to 0x3000 while busy.
      txn(0, 1'b1, 1'b0, 16'h2000, '0, 0, 2, 0, 0, acc);
      chk("addr_change", 0, rdata_w[0], pool_data[0][2]);
      idle(0, 1);
      chk("no_err", 0, lc3b_line'(err_w[0]), '0);

      random_phase(0, 150);

      // Simultaneous read and write is a write plus an error.
      txn(0, 1'b1, 1'b1, 16'h0040, 128'h1, 0, 0, 0, 0, acc);
      idle(0, 1);
      chk("dual_err", 0, lc3b_line'(err_w[0]), 128'h1);
      txn(0, 1'b1, 1'b0, 16'h0040, '0, 0, 0, 0, 0, acc);
      chk("dual_rdata", 0, rdata_w[0], 128'h1);
      idle(0, 1);

      // Operation flip while busy keeps the latched read.
      do_reset(0);
      k1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      txn(0, 1'b0, 1'b1, 16'h0010, k1, 0, 0, 0, 0, acc);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0010, '0, 0, 0, 1, 0, acc);
      chk("flip_rdata", 0, rdata_w[0], k1);
      chk("flip_err", 0, lc3b_line'(err_w[0]), 128'h1);
      idle(0, 1);

      // Abort by dropping the request.
      do_reset(0);
      r1 = resp_cyc[0];
      txn(0, 1'b1, 1'b0, 16'h0000, '0, 2, 0, 0, 0, acc);
      idle(0, 2);
      chk("abort_noresp", 0, lc3b_line'(resp_cyc[0]), lc3b_line'(r1));
      chk("abort_err", 0, lc3b_line'(err_w[0]), 128'h1);

      // Reset during a write leaves the line untouched.
      k2 = {4{32'hC0DE_5EED}};
      txn(0, 1'b0, 1'b1, 16'h0080, k2, 0, 0, 0, 0, acc);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0080, '0, 0, 0, 0, 0, acc);
      idle(0, 1);
      txn(0, 1'b0, 1'b1, 16'h0080, {4{32'hDEAD_BEEF}}, 0, 0, 0, 2, acc);
      idle(0, 1);
      txn(0, 1'b1, 1'b0, 16'h0080, '0, 0, 0, 0, 0, acc);
      chk("rst_keeps_line", 0, rdata_w[0], k2);
      idle(0, 1);

      // LATENCY=1 instance.
      txn(1, 1'b0, 1'b1, 16'h0100, {8{16'h7E57}}, 0, 0, 0, 0, acc);
      idle(1, 1);
      txn(1, 1'b1, 1'b0, 16'h0100, '0, 0, 0, 0, 0, acc);
      chk("l1_latency", 1, lc3b_line'(resp_cyc[1] - acc), lc3b_line'(1));
      chk("l1_rdata", 1, rdata_w[1], {8{16'h7E57}});
      txn(1, 1'b0, 1'b1, 16'h0100, {4{32'h1111_2222}}, 0, 0, 0, 0, acc);
      txn(1, 1'b0, 1'b1, 16'h0108, {4{32'h3333_4444}}, 0, 0, 0, 0, acc);
      txn(1, 1'b1, 1'b0, 16'h0100, '0, 0, 0, 0, 0, acc);
      chk("l1_overlap", 1, rdata_w[1], {4{32'h3333_4444}});
      idle(1, 1);
      random_phase(1, 150);

      idle(0, 3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
